// File: rtl/sap_program_counter.sv
// SAP2 program counter: increment, staged jump target, CALL/RET stack.
// Sticky fault on stack overflow/underflow; synchronous active-low reset.
module sap_program_counter #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic [1:0]         i_stage_enable,
  input  logic [WIDTH/2-1:0] i_stage_data,
  input  logic               i_increment,
  input  logic               i_jump,
  input  logic               i_call,
  input  logic               i_ret,
  output logic [WIDTH-1:0]   o_pc,
  output logic [WIDTH-1:0]   o_target,
  output logic               o_stack_empty,
  output logic               o_stack_full,
  output logic               o_fault
);

  localparam int HW  = WIDTH / 2;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SPW-1:0]   sp_q;
  logic [SPW-1:0]   sp_d;
  logic [SPW-1:0]   sp_dec;
  logic [IW-1:0]    push_idx;
  logic [IW-1:0]    pop_idx;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] tgt_d;
  logic             fault_d;
  logic             push;
  logic [3:0]       cmd;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];

  assign o_stack_empty = (sp_q == '0);
  assign o_stack_full  = (sp_q == SPW'(STACK_DEPTH));

  assign sp_dec   = sp_q - SPW'(1);
  assign push_idx = sp_q[IW-1:0];
  assign pop_idx  = sp_dec[IW-1:0];

  // One-hot command after priority masking: ret > call > jump > increment
  assign cmd[3] = i_ret;
  assign cmd[2] = i_call & ~i_ret;
  assign cmd[1] = i_jump & ~i_call & ~i_ret;
  assign cmd[0] = i_increment & ~i_jump & ~i_call & ~i_ret;

  always_comb begin
    pc_d    = o_pc;
    sp_d    = sp_q;
    fault_d = o_fault;
    push    = 1'b0;
    tgt_d   = o_target;
    if (i_stage_enable[0]) tgt_d[HW-1:0]     = i_stage_data;
    if (i_stage_enable[1]) tgt_d[WIDTH-1:HW] = i_stage_data;
    unique case (1'b1)
      cmd[3]: begin
        if (o_stack_empty) begin
          fault_d = 1'b1;
        end else begin
          sp_d = sp_dec;
          pc_d = stack_q[pop_idx];
        end
      end
      cmd[2]: begin
        if (o_stack_full) begin
          fault_d = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + SPW'(1);
          pc_d = o_target;
        end
      end
      cmd[1]: pc_d = o_target;
      cmd[0]: pc_d = o_pc + WIDTH'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_pc     <= '0;
      o_target <= '0;
      sp_q     <= '0;
      o_fault  <= 1'b0;
    end else if (clk_en) begin
      o_pc     <= pc_d;
      o_target <= tgt_d;
      sp_q     <= sp_d;
      o_fault  <= fault_d;
    end
  end

  // Entry storage carries no reset; only sp defines what is valid
  always_ff @(posedge clk) begin
    if (rst_n && clk_en && push) stack_q[push_idx] <= o_pc;
  end

endmodule

// File: tb/tb_sap_program_counter.sv
// Scoreboard bench for sap_program_counter: directed plan plus random
// commands checked against a queue-based reference model.
module tb_sap_program_counter;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int HW = W / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic [1:0]    i_stage_enable = '0;
  logic [HW-1:0] i_stage_data = '0;
  logic          i_increment = 1'b0;
  logic          i_jump = 1'b0;
  logic          i_call = 1'b0;
  logic          i_ret = 1'b0;
  logic [W-1:0]  o_pc;
  logic [W-1:0]  o_target;
  logic          o_stack_empty;
  logic          o_stack_full;
  logic          o_fault;

  sap_program_counter #(.WIDTH(W), .STACK_DEPTH(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .i_stage_enable (i_stage_enable),
    .i_stage_data   (i_stage_data),
    .i_increment    (i_increment),
    .i_jump         (i_jump),
    .i_call         (i_call),
    .i_ret          (i_ret),
    .o_pc           (o_pc),
    .o_target       (o_target),
    .o_stack_empty  (o_stack_empty),
    .o_stack_full   (o_stack_full),
    .o_fault        (o_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] pc;
    logic [W-1:0] tgt;
    logic         empty;
    logic         full;
    logic         fault;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  int           m_pc;
  int           m_tgt;
  int           m_stk[$];
  bit           m_fault;

  task automatic step(input string nm, input bit rst, input bit en,
                      input bit [1:0] se, input bit [HW-1:0] sd,
                      input bit [3:0] c);
    int   old_tgt;
    exp_t e;
    @(negedge clk);
    rst_n          = ~rst;
    clk_en         = en;
    i_stage_enable = se;
    i_stage_data   = sd;
    {i_ret, i_call, i_jump, i_increment} = c;
    if (rst) begin
      m_pc = 0; m_tgt = 0; m_fault = 0;
      m_stk.delete();
    end else if (en) begin
      old_tgt = m_tgt;
      if (se[0]) m_tgt = (m_tgt & 'hFF00) | int'(sd);
      if (se[1]) m_tgt = (m_tgt & 'h00FF) | (int'(sd) << 8);
      if (c[3]) begin
        if (m_stk.size() == 0) m_fault = 1;
        else m_pc = m_stk.pop_back();
      end else if (c[2]) begin
        if (m_stk.size() == D) m_fault = 1;
        else begin
          m_stk.push_back(m_pc);
          m_pc = old_tgt;
        end
      end else if (c[1]) begin
        m_pc = old_tgt;
      end else if (c[0]) begin
        m_pc = (m_pc + 1) % 65536;
      end
    end
    e.name  = nm;
    e.pc    = W'(m_pc);
    e.tgt   = W'(m_tgt);
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == D);
    e.fault = m_fault;
    sb.push_back(e);
  endtask

  task automatic cmd(input string nm, input bit [3:0] c);
    step(nm, 1'b0, 1'b1, 2'b00, 8'h00, c);
  endtask

  task automatic stage(input string nm, input bit [1:0] se,
                       input bit [HW-1:0] sd);
    step(nm, 1'b0, 1'b1, se, sd, 4'b0000);
  endtask

  // Monitor: every edge with a pending expectation is compared
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (o_pc !== e.pc || o_target !== e.tgt ||
            o_stack_empty !== e.empty || o_stack_full !== e.full ||
            o_fault !== e.fault) begin
          n_bad++;
          $display("FAIL %s: got pc=%h tgt=%h e=%b f=%b flt=%b want pc=%h tgt=%h e=%b f=%b flt=%b",
                   e.name, o_pc, o_target, o_stack_empty, o_stack_full,
                   o_fault, e.pc, e.tgt, e.empty, e.full, e.fault);
        end
      end
    end
  end

  initial begin
    bit [3:0] c;
    step("reset_en0", 1'b1, 1'b0, 2'b11, 8'hAA, 4'b1111);
    step("reset_hold", 1'b1, 1'b0, 2'b00, 8'h00, 4'b0001);
    cmd("inc1", 4'b0001);
    cmd("inc2", 4'b0001);
    cmd("inc3", 4'b0001);
    stage("stage_ff_both", 2'b11, 8'hFF);
    cmd("jump_ffff", 4'b0010);
    cmd("inc_wrap", 4'b0001);

    stage("stage_lo34", 2'b01, 8'h34);
    stage("stage_hi12", 2'b10, 8'h12);
    cmd("jump_1234", 4'b0010);
    step("jump_no_bypass", 1'b0, 1'b1, 2'b01, 8'h56, 4'b0010);

    step("reset_nest", 1'b1, 1'b1, 2'b00, 8'h00, 4'b0000);
    stage("stage_hi00", 2'b10, 8'h00);
    stage("stage_lo10", 2'b01, 8'h10);
    cmd("jump_0010", 4'b0010);
    stage("stage_lo00", 2'b01, 8'h00);
    stage("stage_hi01", 2'b10, 8'h01);
    cmd("call_0100", 4'b0100);
    stage("stage_hi02", 2'b10, 8'h02);
    cmd("call_0200", 4'b0100);
    cmd("ret_0100", 4'b1000);
    cmd("ret_0010", 4'b1000);

    for (int i = 0; i < 4; i++) cmd("call_fill", 4'b0100);
    cmd("call_overflow", 4'b0100);
    cmd("ret_after_full", 4'b1000);
    cmd("call_then", 4'b0100);
    cmd("ret_back2back", 4'b1000);

    step("reset_uf", 1'b1, 1'b1, 2'b00, 8'h00, 4'b0000);
    cmd("ret_underflow", 4'b1000);
    cmd("fault_sticky_inc", 4'b0001);
    cmd("fault_sticky_jmp", 4'b0010);

    step("reset_prio", 1'b1, 1'b1, 2'b00, 8'h00, 4'b0000);
    stage("stage_7777", 2'b11, 8'h77);
    cmd("call_7777", 4'b0100);
    cmd("prio_all", 4'b1111);
    step("gate_call", 1'b0, 1'b0, 2'b11, 8'h99, 4'b0100);
    step("gate_inc", 1'b0, 1'b0, 2'b01, 8'h11, 4'b0001);

    cmd("call_sp1", 4'b0100);
    cmd("call_sp2", 4'b0100);
    step("reset_mid_call", 1'b1, 1'b1, 2'b00, 8'h00, 4'b0100);

    for (int i = 0; i < 3000; i++) begin
      c = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) c = c & 4'b0011;
      step("random",
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 85,
           2'($urandom_range(0, 3)),
           8'($urandom),
           c);
    end

    @(negedge clk);
    rst_n = 1'b1;
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sap_program_counter.md
# sap_program_counter

Program counter for the SAP2 core. It holds the WIDTH-bit instruction address, increments it, and takes jump targets assembled from two byte-wide bus loads. It also provides CALL/RET through an internal return-address stack. o_pc feeds the memory address register stage directly downstream; the byte staging inputs are driven from the 8-bit system bus under controller command.

## Interface
Parameters:
- WIDTH, 16, address width; must be even, the bus carries WIDTH/2 bits.
- STACK_DEPTH, 4, number of return-address entries; must be at least 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- clk_en  in  1  global step enable; no state changes when low, except reset.
- i_stage_enable  in  2  bit0 loads i_stage_data into target[WIDTH/2-1:0]; bit1 loads it into target[WIDTH-1:WIDTH/2].
- i_stage_data  in  WIDTH/2  bus byte to stage.
- i_increment  in  1  o_pc <= o_pc + 1.
- i_jump  in  1  o_pc <= staged target.
- i_call  in  1  push o_pc, then o_pc <= staged target.
- i_ret  in  1  pop the top entry into o_pc.
- o_pc  out  WIDTH  current program counter.
- o_target  out  WIDTH  staged jump target.
- o_stack_empty  out  1  stack holds 0 entries.
- o_stack_full  out  1  stack holds STACK_DEPTH entries.
- o_fault  out  1  sticky flag; set by push-on-full or pop-on-empty.

## Operation
- **Reset**, rst_n=0 at a clk edge, regardless of clk_en:
  - o_pc=0, o_target=0, stack pointer=0, o_fault=0.
  - o_stack_empty=1, o_stack_full=0.
  - Stack entry contents are not reset.
- **Gating**: every command acts only at an edge with clk_en=1 and rst_n=1.
- **Staging** is independent of the PC commands.
  - Both i_stage_enable bits may be set in the same cycle; both halves then take i_stage_data.
  - Staging does not alter o_pc.
- **PC command priority**: i_ret > i_call > i_jump > i_increment. Only the highest asserted command executes; the lower ones are dropped.
- **Target used by jump/call**: the o_target value registered before the edge. There is no bypass of same-cycle staging.
- **Increment** wraps modulo 2^WIDTH: all-ones -> 0.
- **Call, stack not full**:
  - stack[sp] <= o_pc (the current value, not +1); sp <= sp+1; o_pc <= o_target.
  - The controller has already advanced o_pc past the operand bytes before issuing call.
- **Call on full**:
  - o_pc, the stack and sp are unchanged; o_fault <= 1.
  - Lower-priority commands in the same cycle are still dropped.
- **Ret, stack not empty**: sp <= sp-1; o_pc <= stack[sp-1].
- **Ret on empty**: o_pc and sp are unchanged; o_fault <= 1.
- **Fault** stays set until reset.
- **Flags** are derived from the registered sp: o_stack_empty = (sp==0); o_stack_full = (sp==STACK_DEPTH).

## Timing
- All outputs are registered. Each command's effect is visible one cycle after the qualifying edge.
- Back-to-back commands are supported every cycle:
  - A call immediately followed by a ret returns the pushed address on the second edge.
  - A ret immediately after a push to full is legal and clears full.
- clk_en low for any number of cycles freezes all state; commands asserted during that time are ignored.
- Reset during a call or ret cycle: reset wins, and the stack pointer returns to 0.

## Test plan
- Reset and increment: hold rst_n=0 with clk_en=0 -> all outputs at reset values. Then 3 increments -> o_pc=0x0003. Set o_pc=0xFFFF via a jump, then increment -> 0x0000.
- Staging and jump:
  - stage_enable=01 data=0x34, then stage_enable=10 data=0x12 -> o_target=0x1234.
  - jump -> o_pc=0x1234.
  - jump asserted in the same cycle as stage_enable=01 data=0x56 -> o_pc=0x1234 (old target), o_target=0x1256.
- Call/ret nesting with STACK_DEPTH=4:
  - From o_pc=0x0010, call 0x0100, call 0x0200 -> o_pc=0x0200, sp=2.
  - ret -> o_pc=0x0100; ret -> o_pc=0x0010, o_stack_empty=1, o_fault=0.
- Overflow and underflow:
  - 4 calls -> o_stack_full=1. A 5th call -> o_pc unchanged, o_fault=1.
  - After reset, ret on empty -> o_pc unchanged, o_fault=1.
  - Fault stays set through further good commands.
- Priority and gating:
  - ret+call+jump+increment asserted together -> only ret executes.
  - Any command with clk_en=0 -> no state change.
- Reset mid-sequence: with sp=2, assert rst_n=0 in the same cycle as a call -> o_pc=0, o_stack_empty=1, o_fault=0.
